// File: rtl/alu_seq.sv
// alu_seq: registered 16-bit-class ALU with an internal {Z,C,F,N,L} flag register.
// ADDC draws its carry-in from the flag register, so ADD followed by ADDC chains words.
// Optional iterative shift-add multiplier on op 15, compiled in with macro ALU_SEQ_MUL_EN;
// without it op 15 behaves as NOP.
module alu_seq #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags,
  output logic             busy,
  output logic             valid
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,  OP_AND  = 4'd1,  OP_OR   = 4'd2,  OP_XOR  = 4'd3,
    OP_NOT  = 4'd4,  OP_ADD  = 4'd5,  OP_ADDU = 4'd6,  OP_ADDC = 4'd7,
    OP_SUB  = 4'd8,  OP_CMP  = 4'd9,  OP_CMPU = 4'd10, OP_MOV  = 4'd11,
    OP_LSH  = 4'd12, OP_RSH  = 4'd13, OP_ARSH = 4'd14, OP_MUL  = 4'd15
  } op_t;

  // Signed overflow of an addition: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic am, input logic bm, input logic rm);
    return (am == bm) && (rm != am);
  endfunction

  // Signed overflow of a subtraction: operands differ in sign, result sign leaves a's.
  function automatic logic sub_ovf(input logic am, input logic bm, input logic rm);
    return (am != bm) && (rm != am);
  endfunction

  logic signed [WIDTH-1:0] a_s, b_s;
  logic        [SHW-1:0]   n;
  logic                    c_in;
  logic        [WIDTH:0]   sum, diff, lsh_w, rsh_w;
  logic signed [WIDTH:0]   arsh_w;
  logic        [WIDTH-1:0] res_nx;
  logic        [4:0]       flg_nx;
  logic                    fz, fc, ff, fn, fl, upd, cmp_op;

  assign a_s    = a;
  assign b_s    = b;
  assign n      = b[SHW-1:0];
  assign c_in   = (op == OP_ADDC) && flags[3];
  assign sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
  assign diff   = {1'b0, a} - {1'b0, b};
  // Extra bit on the shifted-out side captures the last bit that left the word.
  assign lsh_w  = {1'b0, a} << n;
  assign rsh_w  = {a, 1'b0} >> n;
  assign arsh_w = $signed({a, 1'b0}) >>> n;

  // Single-cycle result and flag values for the op currently presented.
  always_comb begin
    res_nx = result;
    fz     = 1'b0;
    fc     = 1'b0;
    ff     = 1'b0;
    fn     = 1'b0;
    fl     = 1'b0;
    upd    = 1'b1;
    cmp_op = 1'b0;
    case (op)
      OP_AND:  res_nx = a & b;
      OP_OR:   res_nx = a | b;
      OP_XOR:  res_nx = a ^ b;
      OP_NOT:  res_nx = ~a;
      OP_MOV:  res_nx = a;
      OP_ADD, OP_ADDC: begin
        res_nx = sum[WIDTH-1:0];
        fc     = sum[WIDTH];
        ff     = add_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
        fn     = sum[WIDTH-1];
      end
      OP_ADDU: begin
        res_nx = sum[WIDTH-1:0];
        fc     = sum[WIDTH];
      end
      OP_SUB: begin
        res_nx = diff[WIDTH-1:0];
        fc     = diff[WIDTH];
        ff     = sub_ovf(a[WIDTH-1], b[WIDTH-1], diff[WIDTH-1]);
        fn     = diff[WIDTH-1];
      end
      OP_CMP: begin
        res_nx = '0;
        cmp_op = 1'b1;
        fz     = (a == b);
        fn     = (a_s < b_s);
      end
      OP_CMPU: begin
        res_nx = '0;
        cmp_op = 1'b1;
        fz     = (a == b);
        fl     = (a < b);
      end
      OP_LSH: begin
        res_nx = lsh_w[WIDTH-1:0];
        fc     = lsh_w[WIDTH];
      end
      OP_RSH: begin
        res_nx = rsh_w[WIDTH:1];
        fc     = rsh_w[0];
      end
      OP_ARSH: begin
        res_nx = arsh_w[WIDTH:1];
        fc     = arsh_w[0];
      end
      default: upd = 1'b0;
    endcase
    if (!cmp_op) fz = (res_nx == '0);
    flg_nx = upd ? {fz, fc, ff, fn, fl} : flags;
  end

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] acc_p0, mcand_p0, acc_nx;
  logic [WIDTH-1:0]   mplier_p0;
  logic [SHW-1:0]     cnt_p0;

  assign acc_nx = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
`endif

  // Accept ops when idle, register results/flags, run multiplier steps, pulse valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      flags     <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_p0    <= '0;
      mcand_p0  <= '0;
      mplier_p0 <= '0;
      cnt_p0    <= '0;
`endif
    end else begin
      valid <= 1'b0;
      if (start && !busy) begin
`ifdef ALU_SEQ_MUL_EN
        if (op == OP_MUL) begin
          busy      <= 1'b1;
          acc_p0    <= '0;
          mcand_p0  <= {{WIDTH{1'b0}}, a};
          mplier_p0 <= b;
          cnt_p0    <= '0;
        end else
`endif
        begin
          result <= res_nx;
          flags  <= flg_nx;
          valid  <= 1'b1;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      else if (busy) begin
        acc_p0    <= acc_nx;
        mcand_p0  <= mcand_p0 << 1;
        mplier_p0 <= mplier_p0 >> 1;
        cnt_p0    <= cnt_p0 + SHW'(1);
        // Last of WIDTH steps: publish the low half, flag a non-zero high half as carry.
        if (cnt_p0 == SHW'(WIDTH - 1)) begin
          busy   <= 1'b0;
          result <= acc_nx[WIDTH-1:0];
          flags  <= {(acc_nx[WIDTH-1:0] == '0), |acc_nx[2*WIDTH-1:WIDTH], 3'b000};
          valid  <= 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 16;
`ifdef ALU_SEQ_MUL_EN
  localparam int MAXOP = 14;
`else
  localparam int MAXOP = 15;
`endif

  logic         clk = 1'b0;
  logic         reset, start, busy, valid;
  logic [3:0]   op;
  logic [W-1:0] a, b, result;
  logic [4:0]   flags;

  int     n_vec = 0;
  int     n_bad = 0;
  longint m_res = 0;
  longint m_flg = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .result(result), .flags(flags), .busy(busy), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint sgn(input longint v);
    return (v >= (longint'(1) << (W - 1))) ? v - (longint'(1) << W) : v;
  endfunction

  function automatic int out_of_range(input longint v);
    return ((v > (longint'(1) << (W - 1)) - 1) || (v < -(longint'(1) << (W - 1)))) ? 1 : 0;
  endfunction

  // Reference: result and {Z,C,F,N,L} from plain integer arithmetic.
  task automatic model(input int o, input longint x, input longint y);
    longint mask = (longint'(1) << W) - 1;
    longint sx = sgn(x);
    longint sy = sgn(y);
    longint r = 0;
    longint s = 0;
    longint cin = 0;
    int n = int'(y % W);
    int z = 0, c = 0, f = 0, nn = 0, l = 0;
    bit upd = 1;
    bit cmpz = 0;
    case (o)
      1:  r = x & y;
      2:  r = x | y;
      3:  r = x ^ y;
      4:  r = ~x & mask;
      11: r = x;
      5, 6, 7: begin
        cin = (o == 7) ? ((m_flg >> 3) & 1) : 0;
        s = x + y + cin;
        r = s & mask;
        c = int'((s >> W) & 1);
        if (o != 6) begin
          f  = out_of_range(sx + sy + cin);
          nn = int'((r >> (W - 1)) & 1);
        end
      end
      8: begin
        r  = (x - y) & mask;
        c  = (x < y) ? 1 : 0;
        f  = out_of_range(sx - sy);
        nn = int'((r >> (W - 1)) & 1);
      end
      9:  begin r = 0; cmpz = 1; z = (x == y); nn = (sx < sy); end
      10: begin r = 0; cmpz = 1; z = (x == y); l = (x < y); end
      12: begin r = (x << n) & mask; c = (n == 0) ? 0 : int'((x >> (W - n)) & 1); end
      13: begin r = x >> n; c = (n == 0) ? 0 : int'((x >> (n - 1)) & 1); end
      14: begin r = (sx >>> n) & mask; c = (n == 0) ? 0 : int'((x >> (n - 1)) & 1); end
`ifdef ALU_SEQ_MUL_EN
      15: begin s = x * y; r = s & mask; c = ((s >> W) != 0) ? 1 : 0; end
`endif
      default: upd = 0;
    endcase
    if (upd) begin
      if (!cmpz) z = (r == 0);
      m_res = r;
      m_flg = (longint'(z) << 4) | (longint'(c) << 3) | (longint'(f) << 2) |
              (longint'(nn) << 1) | longint'(l);
    end
  endtask

  // Present one single-cycle op; leaves start high so calls chain back-to-back.
  task automatic issue(input int o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = 4'(o); a = x; b = y;
    @(posedge clk); #1;
    model(o, x, y);
    check_eq($sformatf("valid op%0d", o), valid, 1);
    check_eq($sformatf("result op%0d", o), result, m_res);
    check_eq($sformatf("flags op%0d", o), flags, m_flg);
    check_eq($sformatf("busy op%0d", o), busy, 0);
  endtask

  task automatic idle_check();
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    @(posedge clk); #1;
    check_eq("idle valid", valid, 0);
    check_eq("idle result", result, m_res);
    check_eq("idle flags", flags, m_flg);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    m_res = 0; m_flg = 0;
    check_eq("rst result", result, 0);
    check_eq("rst flags", flags, 0);
    check_eq("rst busy", busy, 0);
    check_eq("rst valid", valid, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return W'(1);
      2: return W'(16'h7FFF);
      3: return W'(16'h8000);
      4: return '1;
      default: return W'($urandom);
    endcase
  endfunction

`ifdef ALU_SEQ_MUL_EN
  // MUL with an ignored start injected mid-flight; exact WIDTH-cycle latency.
  task automatic mul_run(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = 4'd15; a = x; b = y;
    @(posedge clk); #1;
    check_eq("mul busy@E", busy, 1);
    check_eq("mul valid@E", valid, 0);
    for (int k = 1; k < W; k++) begin
      @(negedge clk);
      start = (k == 3); op = 4'd5; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      check_eq($sformatf("mul busy k%0d", k), busy, 1);
      check_eq($sformatf("mul valid k%0d", k), valid, 0);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    model(15, x, y);
    check_eq("mul busy end", busy, 0);
    check_eq("mul valid end", valid, 1);
    check_eq("mul result", result, m_res);
    check_eq("mul flags", flags, m_flg);
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    do_reset();

    issue(5, 16'h7FFF, 16'h0001);
    check_eq("add ovf result", result, 16'h8000);
    check_eq("add ovf flags", flags, 5'b00110);
    issue(5, 16'hFFFF, 16'h0001);
    check_eq("add wrap flags", flags, 5'b11000);
    issue(7, 16'h0000, 16'h0000);
    check_eq("addc result", result, 16'h0001);
    check_eq("addc flags", flags, 5'b00000);
    issue(9, 16'hFFFE, 16'h0001);
    check_eq("cmp flags", flags, 5'b00010);
    issue(10, 16'hFFFE, 16'h0001);
    check_eq("cmpu flags", flags, 5'b00000);
    issue(10, 16'h0001, 16'hFFFE);
    check_eq("cmpu lt flags", flags, 5'b00001);
    issue(14, 16'h8001, 16'h0003);
    check_eq("arsh result", result, 16'hF000);
    issue(12, 16'h8001, 16'h0001);
    check_eq("lsh result", result, 16'h0002);
    check_eq("lsh flags", flags, 5'b01000);
    issue(13, 16'h1234, 16'h0000);
    check_eq("rsh0 result", result, 16'h1234);
    check_eq("rsh0 flags", flags, 5'b00000);
    idle_check();
    issue(0, 16'hAAAA, 16'h5555);
    issue(15, 16'h1111, 16'h2222);

`ifdef ALU_SEQ_MUL_EN
    idle_check();
    mul_run(16'h0100, 16'h0101);
    check_eq("mul1 literal", result, 16'h0100);
    check_eq("mul1 flags", flags, 5'b01000);
    mul_run(16'h0003, 16'h0005);
    check_eq("mul2 literal", result, 16'h000F);
    check_eq("mul2 flags", flags, 5'b00000);
    // Abort a MUL with reset five cycles in.
    @(negedge clk);
    start = 1'b1; op = 4'd15; a = 16'h1234; b = 16'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    do_reset();
    @(posedge clk); #1;
    check_eq("abort busy", busy, 0);
    check_eq("abort valid", valid, 0);
    mul_run(W'($urandom), W'($urandom));
`endif

    for (int i = 0; i < 300; i++) begin
      issue($urandom_range(0, MAXOP), pick(), pick());
      if ($urandom_range(0, 3) == 0) idle_check();
      if (i == 150) do_reset();
    end
    idle_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the combinational 16-bit ALU.
- Registers the result and keeps an internal ZCFNL flag register; ADDC takes its carry-in from that register, not from a port.
- Adds an iterative multi-cycle multiply and variable-amount shifts, with a start/busy/valid handshake toward the datapath controller.

Parameters:
- WIDTH, 16, operand/result width in bits (must be ≥4 and a power of two).
- SHW, $clog2(WIDTH), width of shift-amount field taken from b[SHW-1:0] (derived; do not override).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  op request; accepted only on an edge where busy==0.
- op  in  4  operation code, sampled with start.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B / shift amount, sampled with start.
- result  out  WIDTH  registered result; holds until next accepted op.
- flags  out  5  flag register {Z,C,F,N,L}, bit4=Z … bit0=L.
- busy  out  1  high while a multi-cycle op is in flight.
- valid  out  1  one-cycle pulse: result/flags just updated.

Behaviour:
- Reset: result=0, flags=0, busy=0, valid=0, internal counter/accumulators=0. Reset during MUL aborts it; no valid is produced.
- Op codes: 0 NOP, 1 AND, 2 OR, 3 XOR, 4 NOT(a), 5 ADD, 6 ADDU, 7 ADDC, 8 SUB, 9 CMP, 10 CMPU, 11 MOV(a), 12 LSH, 13 RSH, 14 ARSH, 15 MUL.
- Single-cycle ops (0–14), accepted at edge E:
  - result and flags are written at E.
  - valid=1 during the cycle after E.
  - Back-to-back starts give a valid on every cycle.
- NOP: result and flags unchanged; valid still pulses.
- Every non-NOP op writes all 5 flags. Z = (result==0) unless stated otherwise.
- Logic, MOV: C=F=N=L=0.
- ADD, ADDU, ADDC: {C,result}=a+b(+flags.C for ADDC), WIDTH+1-bit sum.
  - ADD, ADDC: F = signed overflow (operand MSBs equal, result MSB differs); N = result MSB.
  - ADDU: F=0, N=0.
  - L=0 for all three.
- SUB: result=a-b; C = borrow (a<b unsigned); F = signed overflow (a,b MSBs differ, result MSB ≠ a MSB); N = result MSB; L=0.
- CMP: result=0; Z=(a==b); N = signed a<b; C=F=L=0.
- CMPU: result=0; Z=(a==b); L = unsigned a<b; C=F=N=0.
- LSH/RSH/ARSH: amount n=b[SHW-1:0].
  - LSH is a logical left shift and RSH a logical right shift by n.
  - ARSH is an arithmetic right shift that replicates the MSB.
  - C = last bit shifted out (0 when n=0); F=N=L=0.
- MUL (only with MUL_EN), accepted at edge E:
  - busy←1 at E; one shift-add step per edge.
  - At edge E+WIDTH: busy←0, result = low WIDTH bits of a×b (unsigned), valid=1 the following cycle.
  - Flags: Z = (low half==0); C = (high half≠0); F=N=L=0.
  - Latency is exactly WIDTH cycles.
- start while busy=1 is ignored: no queuing, no state change.
- a and b may change after acceptance without affecting an op in flight (operands are latched).
- flags are visible combinationally to ADDC on the very next accepted op, so ADD then ADDC forms a multi-word add.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: op 15 is the iterative multiplier described above.
- Undefined: no multiplier logic is compiled. Op 15 behaves exactly as NOP: single cycle, valid pulses, result/flags unchanged, busy never asserts.

Test Plan:
- (WIDTH=16) reset, then ADD a=0x7FFF b=0x0001 → result=0x8000, flags Z0 C0 F1 N1 L0, valid one cycle later.
- ADD a=0xFFFF b=0x0001, next cycle ADDC a=0x0000 b=0x0000 → first result=0x0000 Z1 C1; second result=0x0001 (carry consumed), C0.
- CMP a=0xFFFE(-2) b=0x0001 → N=1 L=0 Z=0 result=0; CMPU same operands → L=0 N=0; CMPU a=1 b=0xFFFE → L=1.
- ARSH a=0x8001 b=0x0003 → result=0xF000, C=0; LSH a=0x8001 b=1 → result=0x0002, C=1; RSH b=0 → result=a, C=0.
- (MUL_EN) MUL a=0x0100 b=0x0101 → busy 16 cycles, result=0x0100, C=1, Z=0. A start issued mid-operation is ignored. A second MUL 3×5 → 0x000F, C=0.
- Assert reset 5 cycles into a MUL → busy=0, result=0, flags=0, no valid. Without MUL_EN, op 15 → no busy, flags unchanged, valid pulses.
